cdb_age_arbiter: RTL and testbench
==================================

# cdb_age_arbiter

- Selects one completed functional-unit result per cycle for broadcast on the CDB.
- Base policy is fixed priority: lowest index wins, so latency-critical FUs sit at low indices.
- Per-requester aging counters override fixed priority when a requester has waited too long.
- Also masks requests squashed by a rollback. Sits between the per-FU CDB entry buffers and the CDB broadcast mux; drives the mux select and the per-entry free signals.

## Interface
- NUM_REQ, default `NUM_FU (8): number of requesters; power of two, ≥2.
- ROB_W, default $clog2(`NUM_ROB): ROB index width.
- STARVE_LIMIT, default 4: wait cycles before override; 1..15.
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- en  in  1  pipeline enable; 0 = no grant, state frozen.
- req  in  NUM_REQ  entry i holds a completed result.
- req_ROB_idx  in  NUM_REQ×ROB_W  ROB index of each entry.
- rollback_en  in  1  rollback this cycle.
- ROB_rollback_idx  in  ROB_W  ROB index of the mispredicted/faulting instruction.
- diff_ROB  in  ROB_W  ROB tail minus ROB_rollback_idx (mod 2^ROB_W).
- gnt  out  NUM_REQ  one-hot grant, or zero.
- gnt_valid  out  1  |gnt.
- gnt_idx  out  $clog2(NUM_REQ)  binary index of the grant; 0 when gnt_valid=0.
- squash  out  NUM_REQ  entry i is killed by rollback this cycle.
- starve_active  out  1  the current grant came from the aging override.

## Operation
- Squash:
  - squash[i] = rollback_en && req[i] && (diff_ROB >= (req_ROB_idx[i] − ROB_rollback_idx) mod 2^ROB_W).
  - The rollback instruction itself (difference 0) is squashed.
- Eligible: elig[i] = req[i] && !squash[i].
- Aging state:
  - age[i] is a 4-bit counter, saturating at STARVE_LIMIT.
  - starved[i] = elig[i] && age[i] == STARVE_LIMIT.
- Starved-group pointer: rr_ptr, $clog2(NUM_REQ) bits.
- Selection:
  - If any starved: grant the first starved index searching rr_ptr, rr_ptr+1, … (wrap mod NUM_REQ), and set starve_active=1.
  - Else: grant the lowest-index elig, with starve_active=0.
- Age update (when en=1, at posedge):
  - elig[i] && !gnt[i] → age[i]+1, saturating.
  - gnt[i] or !elig[i] → age[i] = 0. A squashed or withdrawn request loses its age.
- Pointer update: on a starve_active grant, rr_ptr ← gnt_idx+1 mod NUM_REQ. Otherwise it holds.
- en=0:
  - gnt, gnt_valid, gnt_idx, starve_active are forced to 0.
  - squash is still computed, because rollback cleanup is independent of en.
  - age and rr_ptr hold.
- Reset:
  - age ← 0 and rr_ptr ← 0.
  - During the reset cycle all outputs, including squash, are forced to 0.
  - Reset asserted mid-stream discards all aging history.

## Timing
- Grant is combinational from req/squash and registered state; grant latency is 0 cycles. The CDB entry frees on the same cycle as the grant.
- age and rr_ptr update on posedge clock. Override effects appear the cycle after a counter reaches STARVE_LIMIT.
- Worst-case wait for any continuously eligible requester: STARVE_LIMIT + NUM_REQ − 1 cycles.
- Simultaneous rollback and grant: squashed entries are never granted. If all requests are squashed, gnt_valid=0.
- Exactly one grant per cycle. gnt is always one-hot or zero.
- gnt_idx is consistent with gnt in the same cycle.

## Configuration
- CDB_ARB_AGE_EN defined:
  - Aging counters, rr_ptr and the override are built as described.
- CDB_ARB_AGE_EN undefined:
  - No counters or pointer.
  - Pure lowest-index fixed priority among elig.
  - starve_active tied to 0.
  - Squash and en behaviour unchanged.

## Test plan
- Reset, then req=8'hFF for 3 cycles with STARVE_LIMIT=4, macro on → gnt_idx 0,0,0 and starve_active=0; age[1..7]=3 after the third edge.
- STARVE_LIMIT=3, req=8'b0000_0011 held 8 cycles, macro on → gnt_idx sequence 0,0,0,1,0,0,0,1; starve_active=1 only on the idx-1 cycles. Same stimulus with the macro off → all 0.
- ROB_rollback_idx=10, diff_ROB=4, rollback_en=1, req_ROB_idx[0]=12, req_ROB_idx[1]=20, req=8'b11 → squash=8'b01, gnt_idx=1.
- ROB_rollback_idx=30, diff_ROB=5, req_ROB_idx[2]=1 (ROB_W=5, so the difference wraps to 3), req=8'b100 → squash[2]=1, gnt_valid=0.
- en=0 with req=8'hFF for 5 cycles → gnt=0; ages unchanged. Then en=1 → same grant as before the stall.
- STARVE_LIMIT=2, req=8'b1000_0111 for 6 cycles → idx 7 is granted by override within 2+7 cycles. Assert reset for 1 cycle mid-stream → outputs 0 that cycle and all ages 0 afterwards.

Source files
------------

// File: rtl/cdb_age_arbiter.sv
// CDB result arbiter: lowest-index fixed priority with rollback squash masking.
// Define CDB_ARB_AGE_EN to build per-requester aging counters with a round-robin starvation override.
`ifndef NUM_FU
`define NUM_FU 8
`endif
`ifndef NUM_ROB
`define NUM_ROB 32
`endif

module cdb_age_arbiter #(
  parameter int NUM_REQ      = `NUM_FU,
  parameter int ROB_W        = $clog2(`NUM_ROB),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ROB_W-1:0]   req_ROB_idx,
  input  logic                       rollback_en,
  input  logic [ROB_W-1:0]           ROB_rollback_idx,
  input  logic [ROB_W-1:0]           diff_ROB,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic [NUM_REQ-1:0]         squash,
  output logic                       starve_active
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] squash_c, elig;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid, sel_starve, active;

  // Entry is younger-or-equal to the rollback point when its distance from it fits within diff_ROB.
  always_comb begin
    squash_c = '0;
    for (int i = 0; i < NUM_REQ; i++)
      squash_c[i] = rollback_en && req[i] &&
        (diff_ROB >= ROB_W'(req_ROB_idx[i*ROB_W +: ROB_W] - ROB_rollback_idx));
    elig = req & ~squash_c;
  end

`ifdef CDB_ARB_AGE_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [NUM_REQ-1:0][3:0] age_q, age_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d, scan;
  logic [NUM_REQ-1:0]      starved;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = elig[i] && (age_q[i] == LIM);
  end
`endif

  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_starve = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (elig[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`ifdef CDB_ARB_AGE_EN
    // Descending scan so the starved entry nearest rr_ptr is the last one written.
    scan = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      scan = rr_ptr_q + IDX_W'(k);
      if (starved[scan]) begin
        sel_starve = 1'b1;
        sel_idx    = scan;
      end
    end
`endif
  end

  assign active        = en && !reset;
  assign gnt_valid     = active && sel_valid;
  assign gnt           = gnt_valid ? (NUM_REQ'(1) << sel_idx) : '0;
  assign gnt_idx       = gnt_valid ? sel_idx : '0;
  assign starve_active = active && sel_starve;
  assign squash        = reset ? '0 : squash_c;

`ifdef CDB_ARB_AGE_EN
  always_comb begin
    age_d    = age_q;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] || !elig[i]) age_d[i] = '0;
        else if (age_q[i] < LIM) age_d[i] = age_q[i] + 4'd1;
      if (starve_active) rr_ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      age_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      age_q    <= age_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clock;
`endif

endmodule

// File: tb/tb_cdb_age_arbiter.sv
// Scoreboard bench for cdb_age_arbiter; reference model tracks ages/pointer when CDB_ARB_AGE_EN is defined.
module tb_cdb_age_arbiter;
  localparam int N   = 8;
  localparam int RW  = 5;
  localparam int LIM = 3;

  logic          clock = 1'b0, reset = 1'b1, en = 1'b0, rollback_en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*RW-1:0] req_ROB_idx = '0;
  logic [RW-1:0] ROB_rollback_idx = '0, diff_ROB = '0;
  logic [N-1:0]  gnt, squash;
  logic          gnt_valid, starve_active;
  logic [2:0]    gnt_idx;

  always #5 clock = ~clock;

  cdb_age_arbiter #(.NUM_REQ(N), .ROB_W(RW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .en(en), .req(req), .req_ROB_idx(req_ROB_idx),
    .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx), .diff_ROB(diff_ROB),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .squash(squash),
    .starve_active(starve_active)
  );

  typedef struct {
    logic [N-1:0] gnt;
    int           idx;
    bit           vld;
    logic [N-1:0] sq;
    bit           sa;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   m_age[N];
  int   m_ptr = 0;
  int   ridx[N];
  int   obs_idx, obs_vld, obs_sa;
  logic [N-1:0] obs_gnt, obs_sq;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic e, input logic rb, input logic [N-1:0] r);
    exp_t x, y;
    int d, hit;
    logic [N-1:0] el;
    @(negedge clock);
    reset = rst; en = e; rollback_en = rb; req = r;
    for (int i = 0; i < N; i++) req_ROB_idx[i*RW +: RW] = RW'(ridx[i]);
    x.gnt = '0; x.idx = 0; x.vld = 0; x.sq = '0; x.sa = 0;
    for (int i = 0; i < N; i++) begin
      d = (ridx[i] - int'(ROB_rollback_idx) + 32) % 32;
      x.sq[i] = rb && r[i] && (int'(diff_ROB) >= d);
    end
    el  = r & ~x.sq;
    hit = -1;
`ifdef CDB_ARB_AGE_EN
    for (int k = N-1; k >= 0; k--)
      if (el[(m_ptr + k) % N] && m_age[(m_ptr + k) % N] == LIM) hit = (m_ptr + k) % N;
`endif
    if (rst) x.sq = '0;
    else if (e) begin
      if (hit >= 0) begin
        x.idx = hit; x.vld = 1; x.sa = 1;
      end else
        for (int i = N-1; i >= 0; i--)
          if (el[i]) begin x.idx = i; x.vld = 1; end
      if (x.vld) x.gnt = N'(1) << x.idx;
    end
    sb.push_back(x);
    #1;
    y = sb.pop_front();
    check("gnt",       32'(gnt),           32'(y.gnt));
    check("gnt_valid", 32'(gnt_valid),     32'(y.vld));
    check("gnt_idx",   32'(gnt_idx),       32'(y.idx));
    check("squash",    32'(squash),        32'(y.sq));
    check("starve",    32'(starve_active), 32'(y.sa));
    check("onehot",    32'($onehot0(gnt)), 32'(1));
    obs_idx = int'(gnt_idx); obs_vld = int'(gnt_valid); obs_sa = int'(starve_active);
    obs_gnt = gnt; obs_sq = squash;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_ptr = 0;
    end else if (e) begin
      for (int i = 0; i < N; i++)
        if (!el[i] || (y.vld && y.idx == i)) m_age[i] = 0;
        else if (m_age[i] < LIM) m_age[i]++;
      if (y.sa) m_ptr = (y.idx + 1) % N;
    end
  endtask

  int  exp_seq[8];
  int  seen7;
  logic [N-1:0] rr;

  initial begin
    for (int i = 0; i < N; i++) begin ridx[i] = 0; m_age[i] = 0; end
`ifdef CDB_ARB_AGE_EN
    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    // Reset cycle forces everything low, even with requests and a rollback.
    ROB_rollback_idx = 5'd0; diff_ROB = 5'd31;
    cycle(1, 1, 1, 8'hFF);
    check("rst_gnt_valid", 32'(obs_vld), 32'(0));
    check("rst_squash", 32'(obs_sq), 32'(0));
    diff_ROB = '0;

    for (int c = 0; c < 3; c++) begin
      cycle(0, 1, 0, 8'hFF);
      check("all_req_idx", 32'(obs_idx), 32'(0));
      check("all_req_starve", 32'(obs_sa), 32'(0));
    end

    cycle(1, 1, 0, 8'h00);
    for (int c = 0; c < 8; c++) begin
      cycle(0, 1, 0, 8'b0000_0011);
      check("seq_idx", 32'(obs_idx), 32'(exp_seq[c]));
      check("seq_starve", 32'(obs_sa), 32'(exp_seq[c]));
    end

    cycle(1, 1, 0, 8'h00);
    ridx[0] = 12; ridx[1] = 20; ROB_rollback_idx = 5'd10; diff_ROB = 5'd4;
    cycle(0, 1, 1, 8'b0000_0011);
    check("sq1_squash", 32'(obs_sq), 32'(8'b01));
    check("sq1_idx", 32'(obs_idx), 32'(1));

    ridx[2] = 1; ROB_rollback_idx = 5'd30; diff_ROB = 5'd5;
    cycle(0, 1, 1, 8'b0000_0100);
    check("sq2_squash", 32'(obs_sq), 32'(8'b100));
    check("sq2_valid", 32'(obs_vld), 32'(0));
    ROB_rollback_idx = '0; diff_ROB = '0;
    for (int i = 0; i < N; i++) ridx[i] = 0;

    // Stall: state must freeze while en is low.
    cycle(0, 1, 0, 8'hFF);
    cycle(0, 1, 0, 8'hFF);
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, 0, 8'hFF);
      check("stall_gnt", 32'(obs_gnt), 32'(0));
    end
    cycle(0, 1, 0, 8'hFF);
    cycle(0, 1, 0, 8'hFF);

    cycle(1, 1, 0, 8'h00);
    seen7 = 0;
    for (int c = 0; c < LIM + N - 1; c++) begin
      cycle(0, 1, 0, 8'b1000_0111);
      if (obs_gnt[7]) seen7 = 1;
    end
`ifdef CDB_ARB_AGE_EN
    check("starve_bound_idx7", 32'(seen7), 32'(1));
`else
    check("fixed_no_idx7", 32'(seen7), 32'(0));
`endif
    cycle(1, 1, 0, 8'b1000_0111);
    check("midrst_gnt", 32'(obs_gnt), 32'(0));
    for (int c = 0; c < 4; c++) cycle(0, 1, 0, 8'b1000_0111);

    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) ridx[i] = int'($urandom_range(0, 31));
      ROB_rollback_idx = RW'($urandom_range(0, 31));
      diff_ROB         = RW'($urandom_range(0, 31));
      rr = N'($urandom);
      if ($urandom_range(0, 1) == 0) rr = rr | 8'h81;
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) == 0, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
